// File: rtl/traffic_pkg.sv
// Shared types for the actuated phase scheduler: light codes, phase and
// state enums, and the (phase, state) -> four light bus decode.
package traffic_pkg;

   localparam logic [2:0] LT_RED    = 3'b100;
   localparam logic [2:0] LT_YELLOW = 3'b010;
   localparam logic [2:0] LT_GREEN  = 3'b001;

   typedef enum logic [1:0] {
      PH_MAIN = 2'd0,
      PH_TURN = 2'd1,
      PH_SIDE = 2'd2
   } phase_e;

   typedef enum logic [1:0] {
      ST_GREEN  = 2'd0,
      ST_YELLOW = 2'd1,
      ST_ALLRED = 2'd2
   } state_e;

   // Returns {M1, M2, MT, S}; heads outside the phase set stay red.
   function automatic logic [11:0] phase_lights(phase_e ph, state_e st);
      logic [2:0] on_c;
      logic [3:0] set;
      case (st)
         ST_GREEN:  on_c = LT_GREEN;
         ST_YELLOW: on_c = LT_YELLOW;
         default:   on_c = LT_RED;
      endcase
      case (ph)
         PH_MAIN: set = 4'b1100;
         PH_TURN: set = 4'b1010;
         PH_SIDE: set = 4'b0001;
         default: set = 4'b0000;
      endcase
      return {set[3] ? on_c : LT_RED,
              set[2] ? on_c : LT_RED,
              set[1] ? on_c : LT_RED,
              set[0] ? on_c : LT_RED};
   endfunction

   function automatic phase_e emg_target(logic [1:0] sel);
      case (sel)
         2'd1:    return PH_TURN;
         2'd2:    return PH_SIDE;
         default: return PH_MAIN;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-state interval counter with the fixed comparisons the scheduler FSM
// needs; cleared on every state entry by the caller.
module phase_timer #(
   parameter int MIN_GREEN = 7,
   parameter int MAX_GREEN = 20,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int CW        = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic load_i,
   output logic ge_min_o,
   output logic eq_max_o,
   output logic eq_yel_o,
   output logic eq_ar_o
);

   localparam logic [CW-1:0] CNT_SAT = '1;
   localparam logic [CW-1:0] MIN_M1  = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GREEN - 1);
   localparam logic [CW-1:0] YEL_M1  = CW'(YELLOW_T - 1);
   localparam logic [CW-1:0] AR_M1   = CW'(ALLRED_T - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Saturates so a long main-road dwell never wraps back under the minimum.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = MIN_M1;
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ge_min_o = (cnt_q >= MIN_M1);
   assign eq_max_o = (cnt_q == MAX_M1);
   assign eq_yel_o = (cnt_q == YEL_M1);
   assign eq_ar_o  = (cnt_q == AR_M1);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Sensor-actuated four-head phase scheduler: main green by default, latched
// turn/side requests served in rotation, yellow and all-red clearance, preemption.
module traffic_phase_scheduler
   import traffic_pkg::*;
#(
   parameter int MIN_GREEN = 7,
   parameter int MAX_GREEN = 20,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 2,
   parameter int CW        = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_turn,
   input  logic       req_side,
   input  logic       emg,
   input  logic [1:0] emg_sel,
   output logic [2:0] light_M1,
   output logic [2:0] light_M2,
   output logic [2:0] light_MT,
   output logic [2:0] light_S,
   output logic [1:0] phase,
   output logic       gnt_turn,
   output logic       gnt_side
);

   state_e state_q, state_d;
   phase_e cur_q, cur_d;
   phase_e nxt_q, nxt_d;
   logic   pend_turn_q, pend_turn_d;
   logic   pend_side_q, pend_side_d;
   logic   gnt_turn_q, gnt_turn_d;
   logic   gnt_side_q, gnt_side_d;

   logic   ge_min, eq_max, eq_yel, eq_ar;
   logic   cnt_clr, cnt_load;
   logic   green_exit, held, own_req;
   phase_e emg_tgt;

   phase_timer #(
      .MIN_GREEN (MIN_GREEN),
      .MAX_GREEN (MAX_GREEN),
      .YELLOW_T  (YELLOW_T),
      .ALLRED_T  (ALLRED_T),
      .CW        (CW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (cnt_clr),
      .load_i   (cnt_load),
      .ge_min_o (ge_min),
      .eq_max_o (eq_max),
      .eq_yel_o (eq_yel),
      .eq_ar_o  (eq_ar)
   );

   assign emg_tgt = emg_target(emg_sel);
   assign held    = (state_q == ST_GREEN) && emg && (emg_tgt == cur_q);
   assign own_req = (cur_q == PH_TURN) ? req_turn : req_side;

   always_comb begin
      state_d     = state_q;
      cur_d       = cur_q;
      nxt_d       = nxt_q;
      cnt_clr     = 1'b0;
      cnt_load    = 1'b0;
      green_exit  = 1'b0;
      gnt_turn_d  = 1'b0;
      gnt_side_d  = 1'b0;
      pend_turn_d = pend_turn_q | (req_turn & ~((state_q == ST_GREEN) && (cur_q == PH_TURN)));
      pend_side_d = pend_side_q | (req_side & ~((state_q == ST_GREEN) && (cur_q == PH_SIDE)));

      case (state_q)
         ST_GREEN: begin
            if (emg) begin
               green_exit = (emg_tgt != cur_q);
            end else if (cur_q == PH_MAIN) begin
               green_exit = ge_min && (pend_turn_q || pend_side_q);
            end else begin
               green_exit = (ge_min && !own_req) || eq_max;
            end
            // A held green parks the count at the minimum so release exits at once.
            cnt_load = held;
            if (green_exit) begin
               state_d = ST_YELLOW;
               cnt_clr = 1'b1;
               if (emg) begin
                  nxt_d = emg_tgt;
               end else if (cur_q == PH_MAIN) begin
                  nxt_d = pend_turn_q ? PH_TURN : PH_SIDE;
               end else if (cur_q == PH_TURN) begin
                  nxt_d = pend_side_q ? PH_SIDE : PH_MAIN;
               end else begin
                  nxt_d = PH_MAIN;
               end
            end
         end
         ST_YELLOW: begin
            if (eq_yel) begin
               state_d = ST_ALLRED;
               cnt_clr = 1'b1;
            end
         end
         ST_ALLRED: begin
            if (eq_ar) begin
               state_d    = ST_GREEN;
               cnt_clr    = 1'b1;
               cur_d      = emg ? emg_tgt : nxt_q;
               gnt_turn_d = (cur_d == PH_TURN);
               gnt_side_d = (cur_d == PH_SIDE);
               if (cur_d == PH_TURN) pend_turn_d = 1'b0;
               if (cur_d == PH_SIDE) pend_side_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_ALLRED;
            cnt_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_ALLRED;
         cur_q       <= PH_MAIN;
         nxt_q       <= PH_MAIN;
         pend_turn_q <= 1'b0;
         pend_side_q <= 1'b0;
         gnt_turn_q  <= 1'b0;
         gnt_side_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_q       <= cur_d;
         nxt_q       <= nxt_d;
         pend_turn_q <= pend_turn_d;
         pend_side_q <= pend_side_d;
         gnt_turn_q  <= gnt_turn_d;
         gnt_side_q  <= gnt_side_d;
      end
   end

   assign {light_M1, light_M2, light_MT, light_S} = phase_lights(cur_q, state_q);
   assign phase    = cur_q;
   assign gnt_turn = gnt_turn_q;
   assign gnt_side = gnt_side_q;

endmodule
